// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial add/subtract sequencer around one shared 1-bit full adder.
// Operands are loaded on an accepted start and shifted out LSB first, one
// bit per clock. The adder's sum bits are shifted into the result register
// from the top. The carry is kept in a local flop between bit slices.
// Subtraction is A + ~B + 1. The inverted B is captured at load time and
// the carry flop is seeded with 1.

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  // Next-state logic.
  // - IDLE: loads the operands on start.
  // - RUN: consumes one bit slice per clock. On the last slice it
  //   captures the MSB carry-out, and the carry-in vs carry-out
  //   difference that marks signed overflow.
  // - DONE: lasts exactly one cycle.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = op_a;
          b_sh_d   = op_b ^ {WIDTH{sub}};
          carry_d  = sub;
          cnt_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake flags, plus the adder drive.
  // The adder inputs are held at zero outside RUN, so the shared cell sees
  // a quiet input whenever this sequencer is not using it.
  always_comb begin
    busy   = (state_q == RUN);
    done   = (state_q == DONE);
    fa_a   = busy & a_sh_q[0];
    fa_b   = busy & b_sh_q[0];
    fa_cin = busy & carry_q;
    result = result_q;
    cout   = cout_q;
    ovf    = ovf_q;
  end

endmodule
